// File: rtl/wb_stage_pkg.sv
// Shared types and default widths for the write-back stage.
// The load-timeout option is selected with the WB_LOAD_TIMEOUT_EN macro.
package wb_stage_pkg;
    localparam int WB_WORD_WIDTH     = 32;
    localparam int WB_REG_FILE_DEPTH = 4;
    localparam int WB_TIMEOUT_CYCLES = 15;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;
endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage input bundle and register-file write port of the write-back stage.
// Handshake: valid_in marks a retiring instruction; while freeze is high the upstream holds every MEM-stage input unchanged.
interface wb_stage_if import wb_stage_pkg::*; #(
    parameter int WORD_WIDTH     = WB_WORD_WIDTH,
    parameter int REG_FILE_DEPTH = WB_REG_FILE_DEPTH
);
    logic                      valid_in;
    logic                      wb_en_in;
    logic                      mem_read_in;
    logic [REG_FILE_DEPTH-1:0] dest_in;
    logic [WORD_WIDTH-1:0]     alu_result_in;
    logic [WORD_WIDTH-1:0]     mem_rdata;
    logic                      mem_rvalid;
    logic                      freeze;
    logic                      reg_file_enable;
    logic [REG_FILE_DEPTH-1:0] reg_file_wb_address;
    logic [WORD_WIDTH-1:0]     reg_file_wb_data;
    logic                      fwd_valid;
    logic [REG_FILE_DEPTH-1:0] fwd_dest;
    logic [WORD_WIDTH-1:0]     fwd_data;
    logic                      load_error;

    modport slave (
        input  valid_in, wb_en_in, mem_read_in, dest_in, alu_result_in,
               mem_rdata, mem_rvalid,
        output freeze, reg_file_enable, reg_file_wb_address, reg_file_wb_data,
               fwd_valid, fwd_dest, fwd_data, load_error
    );

    modport master (
        output valid_in, wb_en_in, mem_read_in, dest_in, alu_result_in,
               mem_rdata, mem_rvalid,
        input  freeze, reg_file_enable, reg_file_wb_address, reg_file_wb_data,
               fwd_valid, fwd_dest, fwd_data, load_error
    );
endinterface

// File: rtl/wb_timeout_counter.sv
// Load-wait cycle counter; tc_o flags the last permitted wait cycle.
// Only instantiated when WB_LOAD_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Count k-1 during the k-th wait cycle, so the terminal count lands on wait cycle TIMEOUT_CYCLES.
    assign tc_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_i && !tc_o) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results and load data to the register file, freezing upstream on outstanding loads.
// Define WB_LOAD_TIMEOUT_EN to abort loads that wait TIMEOUT_CYCLES without a response.
module wb_stage import wb_stage_pkg::*; #(
    parameter int WORD_WIDTH     = WB_WORD_WIDTH,
`ifdef WB_LOAD_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
`endif
    parameter int REG_FILE_DEPTH = WB_REG_FILE_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus,
    output wb_state_e  state_o
);
    wb_state_e                 state_q, state_d;
    logic                      en_q, en_d;
    logic [REG_FILE_DEPTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]     data_q, data_d;
    logic [REG_FILE_DEPTH-1:0] pend_q, pend_d;
    logic                      freeze_c;
    logic                      wait_enter;

`ifdef WB_LOAD_TIMEOUT_EN
    logic err_q, err_d;
    logic timeout_hit;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear_i (wait_enter),
        .count_i (state_q == LOAD_WAIT),
        .tc_o    (timeout_hit)
    );
`endif

    always_comb begin
        state_d    = state_q;
        en_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        pend_d     = pend_q;
        freeze_c   = 1'b0;
        wait_enter = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid_in && bus.wb_en_in) begin
                    if (!bus.mem_read_in) begin
                        en_d   = 1'b1;
                        addr_d = bus.dest_in;
                        data_d = bus.alu_result_in;
                    end else if (bus.mem_rvalid) begin
                        en_d   = 1'b1;
                        addr_d = bus.dest_in;
                        data_d = bus.mem_rdata;
                    end else begin
                        freeze_c   = 1'b1;
                        pend_d     = bus.dest_in;
                        wait_enter = 1'b1;
                        state_d    = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (bus.mem_rvalid) begin
                    en_d    = 1'b1;
                    addr_d  = pend_q;
                    data_d  = bus.mem_rdata;
                    state_d = IDLE;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
                else begin
                    freeze_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
`ifdef WB_LOAD_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Upstream may still be presenting a load while reset is low; freeze must not follow it.
    assign bus.freeze              = freeze_c & rst;
    assign bus.reg_file_enable     = en_q;
    assign bus.reg_file_wb_address = addr_q;
    assign bus.reg_file_wb_data    = data_q;
    assign bus.fwd_valid           = en_q;
    assign bus.fwd_dest            = addr_q;
    assign bus.fwd_data            = data_q;
`ifdef WB_LOAD_TIMEOUT_EN
    assign bus.load_error          = err_q;
`else
    assign bus.load_error          = 1'b0;
`endif
    assign state_o                 = state_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writes, zero-wait and multi-cycle loads, stray responses, reset mid-wait, optional timeout.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int W = 36;

  logic      clk;
  logic      rst;
  wb_state_e dbg_state;
  int        n_checks;
  int        n_errors;
  logic [W-1:0] exp_q[$];

  wb_stage_if #(.WORD_WIDTH(32), .REG_FILE_DEPTH(4)) bus ();

  wb_stage #(
    .WORD_WIDTH     (32),
`ifdef WB_LOAD_TIMEOUT_EN
    .TIMEOUT_CYCLES (4),
`endif
    .REG_FILE_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.valid_in      = 1'b0;
    bus.wb_en_in      = 1'b0;
    bus.mem_read_in   = 1'b0;
    bus.dest_in       = '0;
    bus.alu_result_in = '0;
    bus.mem_rdata     = '0;
    bus.mem_rvalid    = 1'b0;
  endtask

  task automatic drive_instr(input logic wb_en, input logic mem_read, input logic [3:0] dest,
                             input logic [31:0] alu, input logic rvalid, input logic [31:0] rdata);
    bus.valid_in      = 1'b1;
    bus.wb_en_in      = wb_en;
    bus.mem_read_in   = mem_read;
    bus.dest_in       = dest;
    bus.alu_result_in = alu;
    bus.mem_rvalid    = rvalid;
    bus.mem_rdata     = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [3:0] dest, input logic [31:0] data);
    check({tag, "_en"},        bus.reg_file_enable, 1);
    check({tag, "_addr"},      bus.reg_file_wb_address, dest);
    check({tag, "_data"},      bus.reg_file_wb_data, data);
    check({tag, "_fwd_valid"}, bus.fwd_valid, 1);
    check({tag, "_fwd_dest"},  bus.fwd_dest, dest);
    check({tag, "_fwd_data"},  bus.fwd_data, data);
  endtask

  // scoreboard: every committed write must match the next expected {address, data}
  always @(negedge clk) begin
    if (rst && bus.reg_file_enable) begin
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("write_payload", {bus.reg_file_wb_address, bus.reg_file_wb_data}, exp_q.pop_front());
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    drive_idle();
    tick();
    tick();
    check("rst_en",    bus.reg_file_enable, 0);
    check("rst_addr",  bus.reg_file_wb_address, 0);
    check("rst_data",  bus.reg_file_wb_data, 0);
    check("rst_freeze", bus.freeze, 0);
    check("rst_err",   bus.load_error, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    tick();

    // ALU write to R3
    drive_instr(1, 0, 4'd3, 32'h0000_00AB, 0, 32'h0);
    #1 check("alu_freeze", bus.freeze, 0);
    exp_q.push_back({4'd3, 32'h0000_00AB});
    tick();
    drive_idle();
    check_write("alu", 4'd3, 32'h0000_00AB);
    check("alu_freeze_after", bus.freeze, 0);
    tick();
    check("alu_strobe_one_cycle", bus.reg_file_enable, 0);

    // back-to-back ALU writes keep the strobe high
    drive_instr(1, 0, 4'd1, 32'h1111_1111, 0, 32'h0);
    exp_q.push_back({4'd1, 32'h1111_1111});
    tick();
    drive_instr(1, 0, 4'd15, 32'hFFFF_FFFF, 0, 32'h0);
    exp_q.push_back({4'd15, 32'hFFFF_FFFF});
    check_write("b2b_first", 4'd1, 32'h1111_1111);
    tick();
    drive_idle();
    check_write("b2b_r15", 4'd15, 32'hFFFF_FFFF);
    tick();
    check("b2b_end_en", bus.reg_file_enable, 0);

    // zero-wait load to R5
    drive_instr(1, 1, 4'd5, 32'h0BAD_0BAD, 1, 32'hDEAD_BEEF);
    #1 check("zload_freeze", bus.freeze, 0);
    exp_q.push_back({4'd5, 32'hDEAD_BEEF});
    tick();
    drive_idle();
    check_write("zload", 4'd5, 32'hDEAD_BEEF);
    check("zload_freeze_after", bus.freeze, 0);
    tick();

    // 3-cycle load to R7; upstream fields change while waiting and must be ignored
    drive_instr(1, 1, 4'd7, 32'h0, 0, 32'h0);
    #1 check("ld3_freeze_c0", bus.freeze, 1);
    tick();
    drive_instr(1, 0, 4'd9, 32'h5A5A_5A5A, 0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      #1 check($sformatf("ld3_freeze_c%0d", c), bus.freeze, 1);
      check($sformatf("ld3_en_c%0d", c), bus.reg_file_enable, 0);
      check($sformatf("ld3_state_c%0d", c), dbg_state, LOAD_WAIT);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    #1 check("ld3_freeze_c3", bus.freeze, 0);
    exp_q.push_back({4'd7, 32'h1234_5678});
    tick();
    drive_idle();
    check_write("ld3", 4'd7, 32'h1234_5678);
    check("ld3_state_done", dbg_state, IDLE);
    tick();

    // store/branch, then a stray read response in IDLE
    drive_instr(0, 0, 4'd2, 32'hCCCC_CCCC, 0, 32'h0);
    #1 check("store_freeze", bus.freeze, 0);
    tick();
    check("store_no_en", bus.reg_file_enable, 0);
    drive_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    #1 check("stray_freeze", bus.freeze, 0);
    tick();
    drive_idle();
    check("stray_no_en", bus.reg_file_enable, 0);
    tick();

    // reset asserted while a load to R4 has waited 2 cycles
    drive_instr(1, 1, 4'd4, 32'h0, 0, 32'h0);
    tick();
    tick();
    check("rstw_freeze_before", bus.freeze, 1);
    #2 rst = 1'b0;
    #1 check("rstw_freeze", bus.freeze, 0);
    check("rstw_en", bus.reg_file_enable, 0);
    check("rstw_state", dbg_state, IDLE);
    drive_idle();
    tick();
    rst = 1'b1;
    tick();
    check("rstw_after_en", bus.reg_file_enable, 0);
    check("rstw_after_state", dbg_state, IDLE);
    tick();
    check("rstw_after_en2", bus.reg_file_enable, 0);

`ifdef WB_LOAD_TIMEOUT_EN
    // response on the terminal wait cycle wins over the timeout
    drive_instr(1, 1, 4'd6, 32'h0, 0, 32'h0);
    #1 check("to_ok_freeze_c0", bus.freeze, 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("to_ok_freeze_c%0d", c), bus.freeze, 1);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    #1 check("to_ok_freeze_c4", bus.freeze, 0);
    exp_q.push_back({4'd6, 32'hCAFE_F00D});
    tick();
    drive_idle();
    check_write("to_ok", 4'd6, 32'hCAFE_F00D);
    check("to_ok_err", bus.load_error, 0);
    tick();

    // no response: abort after 4 wait cycles
    drive_instr(1, 1, 4'd8, 32'h0, 0, 32'h0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("to_ab_freeze_c%0d", c), bus.freeze, 1);
      tick();
    end
    check("to_ab_freeze_c4", bus.freeze, 0);
    tick();
    drive_idle();
    check("to_ab_en", bus.reg_file_enable, 0);
    check("to_ab_err", bus.load_error, 1);
    check("to_ab_state", dbg_state, IDLE);
    drive_instr(1, 0, 4'd2, 32'h0000_0042, 0, 32'h0);
    exp_q.push_back({4'd2, 32'h0000_0042});
    tick();
    drive_idle();
    check_write("to_after", 4'd2, 32'h0000_0042);
    check("to_err_sticky", bus.load_error, 1);
    tick();
`else
    check("no_timeout_err", bus.load_error, 0);
`endif

    tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage ARM pipeline; the producer side of the register-file write port (`reg_file_wb_address`, `reg_file_wb_data`, `reg_file_enable`) that the decode stage consumes.
- Accepts retiring instructions from the MEM pipeline register.
- Waits on a variable-latency data-memory read response for loads, and issues `freeze` to hold the upstream pipeline while a load is outstanding.
- Drives a forwarding tap carrying the value being committed.

Parameters:
- WORD_WIDTH, 32, datapath width.
- REG_FILE_DEPTH, 4, register index width.
- TIMEOUT_CYCLES, 15, max LOAD_WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  MEM-stage entry holds a retiring instruction.
- wb_en_in  in  1  instruction writes a register.
- mem_read_in  in  1  instruction is a load (LDR).
- dest_in  in  REG_FILE_DEPTH  destination register index.
- alu_result_in  in  WORD_WIDTH  ALU result (non-load write data).
- mem_rdata  in  WORD_WIDTH  memory read data.
- mem_rvalid  in  1  `mem_rdata` valid this cycle.
- freeze  out  1  stall upstream stages (combinational).
- reg_file_enable  out  1  register-file write strobe (registered).
- reg_file_wb_address  out  REG_FILE_DEPTH  write index (registered).
- reg_file_wb_data  out  WORD_WIDTH  write data (registered).
- fwd_valid  out  1  equals `reg_file_enable`; forwarding tap.
- fwd_dest  out  REG_FILE_DEPTH  equals `reg_file_wb_address`.
- fwd_data  out  WORD_WIDTH  equals `reg_file_wb_data`.
- load_error  out  1  sticky timeout flag (optional feature; tied 0 when absent).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - `reg_file_enable`, `reg_file_wb_address`, `reg_file_wb_data`, `load_error` = 0.
  - `freeze` = 0.
- States: IDLE, LOAD_WAIT.
- IDLE, with `valid_in`=1, `wb_en_in`=1, `mem_read_in`=0:
  - Next edge registers `reg_file_enable`=1, address=`dest_in`, data=`alu_result_in`.
  - Latency 1 cycle; the strobe lasts exactly one cycle unless the next instruction also writes.
- IDLE, with `valid_in`=1, `wb_en_in`=1, `mem_read_in`=1:
  - If `mem_rvalid`=1 in the same cycle: commit `mem_rdata` at the next edge, as above; `freeze` stays 0.
  - Otherwise: `freeze`=1 combinationally that cycle; latch `dest_in` into the pending-destination register; go to LOAD_WAIT; `reg_file_enable`=0 next cycle.
- IDLE, with `valid_in`=0 or `wb_en_in`=0: no write; `reg_file_enable`=0 next cycle.
- LOAD_WAIT:
  - `freeze`=1 while `mem_rvalid`=0.
  - All MEM-stage inputs are ignored; upstream holds them.
  - On `mem_rvalid`=1: `freeze`=0 that same cycle. Next edge commits `mem_rdata` to the pending destination and returns to IDLE.
- `mem_rvalid` in IDLE with no load presented: ignored.
- Write to any index, including 15, is committed as-is; PC handling lives elsewhere.
- Data is the full WORD_WIDTH; there is no byte/halfword extension.
- Reset asserted in LOAD_WAIT: the pending load is discarded, no write occurs, and `freeze` drops immediately.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to LOAD_WAIT and increments each LOAD_WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without `mem_rvalid`, the load is aborted: no register write, return to IDLE, `freeze`=0 that cycle.
  - `load_error` is set and stays sticky until reset.
  - `mem_rvalid` in the terminal count cycle wins over the timeout, and the load commits normally.
- Without the macro: LOAD_WAIT waits indefinitely, there is no counter, and `load_error` is constant 0.

Decomposition:
- Shared package: the state enum (IDLE, LOAD_WAIT) and the WORD_WIDTH/REG_FILE_DEPTH constants, which align with the global settings header.
- One natural sub-module, wb_timeout_counter (clear, count, terminal-count output), instantiated only under WB_LOAD_TIMEOUT_EN.

Test Plan:
- ALU write:
  - Stimulus: `valid_in`=1, `wb_en_in`=1, `mem_read_in`=0, `dest_in`=3, `alu_result_in`=0x0000_00AB.
  - Response: next cycle `reg_file_enable`=1, address=3, data=0xAB, `fwd_*` equal; `freeze` never 1.
- Zero-wait load:
  - Stimulus: load to R5 with `mem_rvalid`=1 and `mem_rdata`=0xDEAD_BEEF in the same cycle.
  - Response: next cycle writes R5=0xDEADBEEF; `freeze`=0 throughout.
- 3-cycle load:
  - Stimulus: load to R7; `mem_rvalid` arrives 3 cycles later with 0x1234_5678.
  - Response: `freeze`=1 for exactly 3 cycles; write of R7=0x12345678 one cycle after `rvalid`.
- Store/branch:
  - Stimulus: `valid_in`=1, `wb_en_in`=0.
  - Response: no `reg_file_enable`; a stray `mem_rvalid` in IDLE causes no write.
- Reset mid-wait:
  - Stimulus: load pending 2 cycles, then rst=0 asynchronously.
  - Response: `freeze` and `reg_file_enable` go 0 immediately; after release, state is IDLE and no write occurs.
- Timeout (WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: load with no `rvalid`.
  - Response: abort after 4 wait cycles, `load_error`=1 sticky, no write.
  - Repeat with `rvalid` on cycle 4: normal commit, `load_error` stays 0.
